ex_issue_ctrl: RTL



---
 rtl/ex_issue_ctrl_pkg.sv | 24 ++
 rtl/ex_mul_tracker.sv | 42 ++++
 rtl/ex_issue_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/ex_issue_ctrl_pkg.sv
// Shared constants and types for the execute-stage issue controller.
package ex_issue_ctrl_pkg;

    // Default multiplier latency (accept to result), legal range 2..15.
    localparam int unsigned MUL_LAT_DEFAULT = 3;

    // Default width of the per-lane latency counter.
    localparam int unsigned CNT_W_DEFAULT = 4;

    // Full SIMD result width; non-SIMD results are 32-bit.
    localparam int unsigned SIMD_DATA_WIDTH = 128;

    // Kind of operation held in one issue lane.
    typedef enum logic {
        OP_ALU = 1'b0,
        OP_MUL = 1'b1
    } opKind_e;

    // Classify a lane's operation from its is_mul flag.
    function automatic opKind_e laneKind(input logic isMul);
        return isMul ? OP_MUL : OP_ALU;
    endfunction

endpackage

// File: rtl/ex_mul_tracker.sv
// Per-lane multiplier latency tracker: counts down an accepted multiply and
// raises a one-cycle result strobe when it completes.
module ex_mul_tracker
    import ex_issue_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic start,
    output logic busy,
    output logic mEn
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Latency counter and result strobe; result fires the cycle after cnt==1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            mEn <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
            mEn <= 1'b0;
        end else begin
            if (start) begin
                cnt <= LOAD_VAL;
            end else if (cnt != '0) begin
                cnt <= cnt - ONE;
            end
            mEn <= (cnt == ONE);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller for the two-lane integer pipe: accepts a
// bundle, starts multiplies, produces ALU/multiplier result strobes and the
// SIMD qualifier, and stalls issue while any multiply is in flight.
module ex_issue_ctrl
    import ex_issue_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_valid_0,
    input  logic issue_valid_1,
    input  logic issue_is_mul_0,
    input  logic issue_is_mul_1,
    input  logic issue_simd,
    input  logic flush,
    output logic issue_ready,
    output logic mul_start_0,
    output logic mul_start_1,
    output logic alu_ic_en_0,
    output logic alu_ic_en_1,
    output logic alu_m_en_0,
    output logic alu_m_en_1,
    output logic simd_ena
);

    logic    busy0;
    logic    busy1;
    logic    accept;
    opKind_e kind0;
    opKind_e kind1;

    assign kind0 = laneKind(issue_is_mul_0);
    assign kind1 = laneKind(issue_is_mul_1);

    // Holding off issue until both trackers drain keeps ALU and multiplier
    // results from ever landing on the same lane in the same cycle.
    assign issue_ready = ~flush & ~busy0 & ~busy1;
    assign accept      = issue_ready & (issue_valid_0 | issue_valid_1);
    assign mul_start_0 = accept & issue_valid_0 & (kind0 == OP_MUL);
    assign mul_start_1 = accept & issue_valid_1 & (kind1 == OP_MUL);

    // ALU result strobes: one cycle after an accepted ALU op; flush blocks accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ic_en_0 <= 1'b0;
            alu_ic_en_1 <= 1'b0;
        end else begin
            alu_ic_en_0 <= accept & issue_valid_0 & (kind0 == OP_ALU);
            alu_ic_en_1 <= accept & issue_valid_1 & (kind1 == OP_ALU);
        end
    end

    // SIMD qualifier: captured on every accept, held through multiply completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            simd_ena <= 1'b0;
        end else if (accept) begin
            simd_ena <= issue_simd;
        end
    end

    ex_mul_tracker #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) mulTrk0 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (mul_start_0),
        .busy  (busy0),
        .mEn   (alu_m_en_0)
    );

    ex_mul_tracker #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) mulTrk1 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (mul_start_1),
        .busy  (busy1),
        .mEn   (alu_m_en_1)
    );

endmodule
